// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: four-way round-robin arbiter for a shared 32-bit mux port.
// Grants one requester at a time, drives the mux select, and revokes a grant
// that has been held for MAX_HOLD consecutive cycles.
module mem_port_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] done,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       busy,
  output logic       timeout
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LIMIT = HW'(MAX_HOLD - 1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t          state_reg, state_next;
  logic [1:0]      ptr_reg, ptr_next;
  logic [1:0]      owner_reg, owner_next;
  logic [HW-1:0]   hold_reg, hold_next;
  logic [3:0]      gnt_reg, gnt_next;
  logic            busy_reg, busy_next;
  logic            timeout_reg, timeout_next;

  // Candidate indices in priority order: ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  logic [1:0] cand_idx [4];
  logic [3:0] cand_hit;
  logic [1:0] pick;
  logic       release_now;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cand
      assign cand_idx[gi] = ptr_reg + 2'(gi);
      assign cand_hit[gi] = req[cand_idx[gi]];
    end
  endgenerate

  // Choose the first requesting candidate; lowest rotation offset wins.
  always_comb begin
    pick = ptr_reg;
    for (int i = 3; i >= 0; i--) begin
      if (cand_hit[i]) pick = cand_idx[i];
    end
  end

  // Owner gives the port back either by strobing done or by dropping req.
  assign release_now = done[owner_reg] | ~req[owner_reg];

  // State register; reset clears the grant immediately, without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= 2'd0;
      owner_reg   <= 2'd0;
      hold_reg    <= '0;
      gnt_reg     <= 4'd0;
      busy_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      owner_reg   <= owner_next;
      hold_reg    <= hold_next;
      gnt_reg     <= gnt_next;
      busy_reg    <= busy_next;
      timeout_reg <= timeout_next;
    end
  end

  // Next-state logic: arbitrate in IDLE, watch release and hold limit in GRANT.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    owner_next   = owner_reg;
    hold_next    = hold_reg;
    gnt_next     = gnt_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        gnt_next = 4'd0;
        if (|req) begin
          owner_next = pick;
          gnt_next   = 4'b0001 << pick;
          ptr_next   = pick + 2'd1;
          hold_next  = '0;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          // A normal release wins over a simultaneous hold-limit expiry.
          gnt_next   = 4'd0;
          state_next = IDLE;
        end else if (hold_reg == HOLD_LIMIT) begin
          gnt_next     = 4'd0;
          timeout_next = 1'b1;
          state_next   = IDLE;
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end
      default: begin
        gnt_next   = 4'd0;
        state_next = IDLE;
      end
    endcase
    busy_next = |gnt_next;
  end

  // The select is the current or most recent owner, so it only moves on a new grant.
  assign gnt     = gnt_reg;
  assign sel     = owner_reg;
  assign busy    = busy_reg;
  assign timeout = timeout_reg;

endmodule
